wb_interconnect: RTL and testbench
==================================

# wb_interconnect

Parametrised Wishbone (classic, single-transfer) shared-bus interconnect joining NUM_M `wishbone_master` instances to NUM_S `wishbone_slave` instances inside `top`. It replaces the fixed one-to-one master/slave wiring and adds:
- round-robin arbitration;
- address decoding;
- an error response for unmapped addresses and for slaves that stall.

## Interface
Parameters:
- NUM_M, 2 — number of masters (1..8)
- NUM_S, 4 — number of slaves (1..16)
- ADR_W, 32 — address width
- DAT_W, 32 — data width, multiple of 8; SEL_W = DAT_W/8
- DEC_LSB, 28 — lowest address bit of the slave-select field, width SW = clog2(NUM_S) (min 1)
- TIMEOUT, 255 — stall cycles before error, 1..65535

Ports (per-master / per-slave buses are flattened, index 0 in the LSBs):
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- m_cyc_i  in  NUM_M  master bus request
- m_stb_i  in  NUM_M  master strobe
- m_we_i  in  NUM_M  write enable
- m_adr_i  in  NUM_M*ADR_W  addresses
- m_dat_i  in  NUM_M*DAT_W  write data
- m_sel_i  in  NUM_M*SEL_W  byte selects
- m_dat_o  out  DAT_W  read data, broadcast to all masters
- m_ack_o  out  NUM_M  acknowledge, owner only
- m_err_o  out  NUM_M  error, owner only
- m_gnt_o  out  NUM_M  one-hot grant (registered)
- s_cyc_o  out  NUM_S  per-slave cycle
- s_stb_o  out  NUM_S  per-slave strobe
- s_we_o  out  1  shared
- s_adr_o  out  ADR_W  shared
- s_dat_o  out  DAT_W  shared
- s_sel_o  out  SEL_W  shared
- s_dat_i  in  NUM_S*DAT_W  slave read data
- s_ack_i  in  NUM_S  slave acknowledge

## Operation
State machine states:
- IDLE: no owner. On each edge, if any m_cyc_i is high, grant the first requester found searching upward (wrapping) from rr_ptr+1. Then gnt←one-hot, owner←index, go to BUSY.
- BUSY: the owner's signals are muxed to the shared s_* outputs.
  - On an edge where the owner's m_cyc_i is low, set rr_ptr←owner.
  - In that same edge, re-arbitrate among the remaining requesters. If one exists, stay in BUSY with the new owner; otherwise go to IDLE and set gnt←0.
- The owner can never be preempted while its m_cyc_i is high.

Address decode (combinational from the owner's address):
- idx = adr[DEC_LSB +: SW].
- Mapped (idx < NUM_S): s_cyc_o[idx] = owner cyc and s_stb_o[idx] = owner stb; all other bits are 0. m_dat_o = s_dat_i[idx]. m_ack_o[owner] = s_ack_i[idx].
- Unmapped (idx ≥ NUM_S): no slave strobed. m_err_o[owner] = owner stb, combinationally (same cycle as stb).

Timeout counter:
- Counts cycles in which the owner's stb is high on a mapped slave with no ack.
- When the count reaches TIMEOUT, m_err_o[owner] pulses for exactly one cycle (registered) and the counter clears.
- The counter also clears on ack, on stb low, and on owner change.
- An s_ack_i arriving in the same cycle as the timeout pulse wins: ack is passed and err is suppressed.
- ack and err are never both high to one master.

Outputs to non-owner masters: ack/err are 0; m_dat_o is still driven (broadcast).

## Timing
Reset (rst_i low, asynchronous):
- state=IDLE, gnt=0, rr_ptr=NUM_M-1, counter=0.
- All s_cyc_o, s_stb_o, m_ack_o, m_err_o are 0.
- Mid-transfer reset drops s_cyc_o/s_stb_o immediately.

Latencies:
- Arbitration: request sampled at edge N → m_gnt_o and s_stb_o high after edge N (1 cycle).
- Data path: zero added cycles. Slave ack is returned to the master in the same cycle.
- Hand-over: owner drops cyc before edge K → new owner strobes slaves after edge K. There is no bubble cycle.
- Timeout err: asserted in the cycle after the TIMEOUT-th stalled cycle.

## Structure
- Shared package wb_pkg holds:
  - state enum (IDLE, BUSY);
  - default DAT_W/ADR_W constants;
  - a clog2 function.
- Sub-module wb_rr_arbiter(NUM_M) contains the round-robin search. It takes req, rr_ptr and enable, and returns a one-hot grant plus a valid flag.
- Decode, muxing and the timeout counter stay in wb_interconnect.

## Test plan
- Single master write: M0 cyc/stb, we=1, adr=0x1000_0004, dat=0xDEAD_BEEF → s_stb_o=4'b0010 one cycle after request; slave 1 ack → m_ack_o[0] in the same cycle; s_dat_o=0xDEAD_BEEF.
- Fairness: M0 and M1 both hold cyc continuously, each doing 1-transfer tenures then dropping cyc for 1 cycle → grants alternate M0,M1,M0,M1 with no idle cycle between owners.
- Unmapped address (NUM_S=3): M1 reads adr=0x3000_0000 → no s_stb_o asserted; m_err_o[1]=1 in the same cycle as stb.
- Stall timeout (TIMEOUT=4): slave 2 never acks → m_err_o[0] pulses exactly in cycle 5 after stb and for one cycle only; a read with ack in cycle 4 → ack, no err.
- Reset mid-transfer: assert rst_i low while M0 is owner with stb high → all s_stb_o/s_cyc_o/m_gnt_o go to 0 asynchronously; after release, M1 requesting alone is granted one cycle later.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone interconnect.
// Holds the owner FSM state type and width helpers.
package wb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int ADR_W_DEF = 32;
  localparam int DAT_W_DEF = 32;

  // Ceiling log2, never below 1 so select fields keep at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin search: first requester above ptr_i, wrapping.
// Combinational; the caller registers the resulting grant.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_M = 2,
  localparam int PW = clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  input  logic             en_i,
  output logic [NUM_M-1:0] gnt_o,
  output logic             vld_o
);

  // Two passes: indices above the pointer first, then the wrapped part.
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (en_i && !vld_o && req_i[i] && i > int'(ptr_i)) begin
        gnt_o[i] = 1'b1;
        vld_o    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_M; i++) begin
      if (en_i && !vld_o && req_i[i] && i <= int'(ptr_i)) begin
        gnt_o[i] = 1'b1;
        vld_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_interconnect.sv
// Shared-bus Wishbone interconnect: round-robin masters,
// address-decoded slaves, error on unmapped or stalled access.
module wb_interconnect
  import wb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int NUM_S   = 4,
  parameter int ADR_W   = ADR_W_DEF,
  parameter int DAT_W   = DAT_W_DEF,
  parameter int DEC_LSB = 28,
  parameter int TIMEOUT = 255,
  localparam int SEL_W  = DAT_W / 8,
  localparam int MW     = clog2(NUM_M),
  localparam int SW     = clog2(NUM_S)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_M-1:0]       m_cyc_i,
  input  logic [NUM_M-1:0]       m_stb_i,
  input  logic [NUM_M-1:0]       m_we_i,
  input  logic [NUM_M*ADR_W-1:0] m_adr_i,
  input  logic [NUM_M*DAT_W-1:0] m_dat_i,
  input  logic [NUM_M*SEL_W-1:0] m_sel_i,
  output logic [DAT_W-1:0]       m_dat_o,
  output logic [NUM_M-1:0]       m_ack_o,
  output logic [NUM_M-1:0]       m_err_o,
  output logic [NUM_M-1:0]       m_gnt_o,
  output logic [NUM_S-1:0]       s_cyc_o,
  output logic [NUM_S-1:0]       s_stb_o,
  output logic                   s_we_o,
  output logic [ADR_W-1:0]       s_adr_o,
  output logic [DAT_W-1:0]       s_dat_o,
  output logic [SEL_W-1:0]       s_sel_o,
  input  logic [NUM_S*DAT_W-1:0] s_dat_i,
  input  logic [NUM_S-1:0]       s_ack_i
);

  state_e           state_q;
  logic [NUM_M-1:0] gnt_q;
  logic [MW-1:0]    own_q;
  logic [MW-1:0]    rr_q;
  logic [15:0]      cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  logic             busy;
  logic             o_cyc, o_stb, o_we;
  logic [ADR_W-1:0] o_adr;
  logic [DAT_W-1:0] o_dat;
  logic [SEL_W-1:0] o_sel;

  logic [SW-1:0]    idx;
  logic [NUM_S-1:0] hit;
  logic             mapped;
  logic             sack;
  logic [DAT_W-1:0] sdat;
  logic             stall;

  logic [NUM_M-1:0] arb_gnt;
  logic             arb_vld;
  logic [MW-1:0]    arb_idx;

  assign busy    = (state_q == BUSY);
  assign m_gnt_o = gnt_q;

  // Select the current owner's request signals.
  always_comb begin
    o_cyc = 1'b0;
    o_stb = 1'b0;
    o_we  = 1'b0;
    o_adr = '0;
    o_dat = '0;
    o_sel = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (own_q == MW'(i)) begin
        o_cyc = m_cyc_i[i];
        o_stb = m_stb_i[i];
        o_we  = m_we_i[i];
        o_adr = m_adr_i[i*ADR_W +: ADR_W];
        o_dat = m_dat_i[i*DAT_W +: DAT_W];
        o_sel = m_sel_i[i*SEL_W +: SEL_W];
      end
    end
  end

  assign idx = o_adr[DEC_LSB +: SW];

  // Decode the slave field; indices past NUM_S stay unmapped.
  always_comb begin
    hit    = '0;
    mapped = 1'b0;
    sack   = 1'b0;
    sdat   = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (idx == SW'(s)) begin
        hit[s] = 1'b1;
        mapped = 1'b1;
        sack   = s_ack_i[s];
        sdat   = s_dat_i[s*DAT_W +: DAT_W];
      end
    end
  end

  assign s_cyc_o = (busy && o_cyc) ? hit : '0;
  assign s_stb_o = (busy && o_stb) ? hit : '0;
  assign s_we_o  = o_we;
  assign s_adr_o = o_adr;
  assign s_dat_o = o_dat;
  assign s_sel_o = o_sel;
  assign m_dat_o = sdat;

  // Route ack/err to the owner only; a slave ack masks a timeout.
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (busy && own_q == MW'(i)) begin
        m_ack_o[i] = mapped & sack;
        m_err_o[i] = (o_stb & ~mapped)
                   | (tmo_q & ~(mapped & sack));
      end
    end
  end

  wb_rr_arbiter #(
    .NUM_M (NUM_M)
  ) u_arb (
    .req_i (m_cyc_i),
    .ptr_i (busy ? own_q : rr_q),
    .en_i  (~busy | ~o_cyc),
    .gnt_o (arb_gnt),
    .vld_o (arb_vld)
  );

  // One-hot grant to owner index.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (arb_gnt[i]) arb_idx = MW'(i);
    end
  end

  // Ownership FSM: hand over on the edge where the owner drops cyc.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      rr_q    <= MW'(NUM_M - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arb_vld) begin
            state_q <= BUSY;
            gnt_q   <= arb_gnt;
            own_q   <= arb_idx;
          end
        end
        BUSY: begin
          if (!o_cyc) begin
            rr_q <= own_q;
            if (arb_vld) begin
              gnt_q <= arb_gnt;
              own_q <= arb_idx;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A stall needs a live strobe on a mapped slave without ack;
  // dropping cyc (the only way ownership moves) clears it too.
  assign stall = busy & o_cyc & o_stb & mapped & ~sack;

  // Stall counter: fire a one-cycle error after TIMEOUT stalls.
  always_comb begin
    cnt_d = '0;
    tmo_d = 1'b0;
    if (stall) begin
      if (cnt_q == 16'(TIMEOUT - 1)) tmo_d = 1'b1;
      else cnt_d = cnt_q + 16'd1;
    end
  end

  // Register stall count and timeout pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect: grant, fairness,
// unmapped error, stall timeout and asynchronous reset.
module tb_wb_interconnect;

  localparam int NM = 2;
  localparam int NS = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NM-1:0] m_cyc_i, m_stb_i, m_we_i;
  logic [63:0]   m_adr_i, m_dat_i;
  logic [7:0]    m_sel_i;
  logic [31:0]   m_dat_o;
  logic [NM-1:0] m_ack_o, m_err_o, m_gnt_o;
  logic [NS-1:0] s_cyc_o, s_stb_o;
  logic          s_we_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic [3:0]    s_sel_o;
  logic [95:0]   s_dat_i;
  logic [NS-1:0] s_ack_i;

  int n_tot = 0;
  int n_bad = 0;

  wb_interconnect #(
    .NUM_M   (NM),
    .NUM_S   (NS),
    .ADR_W   (32),
    .DAT_W   (32),
    .DEC_LSB (28),
    .TIMEOUT (4)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_sel_i (m_sel_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_gnt_o (m_gnt_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic setm(input int m, input logic cyc,
                      input logic stb, input logic we,
                      input logic [31:0] adr,
                      input logic [31:0] dat);
    m_cyc_i[m]          = cyc;
    m_stb_i[m]          = stb;
    m_we_i[m]           = we;
    m_adr_i[m*32 +: 32] = adr;
    m_dat_i[m*32 +: 32] = dat;
    m_sel_i[m*4 +: 4]   = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i   = 1'b0;
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = '0;
    m_adr_i = '0;
    m_dat_i = '0;
    m_sel_i = '0;
    s_ack_i = '0;
    s_dat_i = {32'h2222_2222, 32'h1111_1111, 32'h0A0A_0A0A};

    #3;
    chk("rst_gnt", m_gnt_o, 0);
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_ack", m_ack_o, 0);
    chk("rst_err", m_err_o, 0);
    #4 rst_i = 1'b1;
    step();

    // single master write to slave 1
    setm(0, 1, 1, 1, 32'h1000_0004, 32'hDEAD_BEEF);
    #1;
    chk("wr_pre_gnt", m_gnt_o, 0);
    chk("wr_pre_stb", s_stb_o, 0);
    step();
    chk("wr_gnt", m_gnt_o, 2'b01);
    chk("wr_stb", s_stb_o, 3'b010);
    chk("wr_cyc", s_cyc_o, 3'b010);
    chk("wr_we", s_we_o, 1);
    chk("wr_adr", s_adr_o, 32'h1000_0004);
    chk("wr_dat", s_dat_o, 32'hDEAD_BEEF);
    chk("wr_ack_pre", m_ack_o, 0);
    s_ack_i = 3'b010;
    #1;
    chk("wr_ack", m_ack_o, 2'b01);
    chk("wr_err", m_err_o, 0);
    chk("wr_rdat", m_dat_o, 32'h1111_1111);
    setm(0, 0, 0, 0, 0, 0);
    s_ack_i = '0;
    step();
    chk("wr_rel_gnt", m_gnt_o, 0);
    chk("wr_rel_stb", s_stb_o, 0);

    // fairness: rr_ptr now 0, so M1 wins first
    setm(0, 1, 1, 0, 32'h0000_0000, 0);
    setm(1, 1, 1, 0, 32'h1000_0000, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      int o;
      logic [2:0] sb;
      o  = (i % 2 == 0) ? 1 : 0;
      sb = (o == 1) ? 3'b010 : 3'b001;
      #1;
      chk("fair_gnt", m_gnt_o, 64'(1 << o));
      chk("fair_stb", s_stb_o, sb);
      s_ack_i = sb;
      #1;
      chk("fair_ack", m_ack_o, 64'(1 << o));
      m_cyc_i[o] = 1'b0;
      m_stb_i[o] = 1'b0;
      s_ack_i    = '0;
      step();
      m_cyc_i[o] = 1'b1;
      m_stb_i[o] = 1'b1;
    end
    m_cyc_i = '0;
    m_stb_i = '0;
    step();
    chk("fair_idle", m_gnt_o, 0);

    // unmapped slave index 3
    setm(1, 1, 1, 0, 32'h3000_0000, 0);
    step();
    chk("um_gnt", m_gnt_o, 2'b10);
    chk("um_stb", s_stb_o, 0);
    chk("um_cyc", s_cyc_o, 0);
    chk("um_err", m_err_o, 2'b10);
    chk("um_ack", m_ack_o, 0);
    m_stb_i[1] = 1'b0;
    #1;
    chk("um_nostb", m_err_o, 0);
    setm(1, 0, 0, 0, 0, 0);
    step();

    // stall timeout on slave 2: err in cycle 5 only
    setm(0, 1, 1, 0, 32'h2000_0000, 0);
    step();
    chk("to_stb", s_stb_o, 3'b100);
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("to_err_c%0d", c), m_err_o,
          (c == 5) ? 64'd1 : 64'd0);
      chk("to_ack", m_ack_o, 0);
      step();
    end
    setm(0, 0, 0, 0, 0, 0);
    step();

    // ack in cycle 4 beats the timeout
    setm(0, 1, 1, 0, 32'h2000_0000, 0);
    step();
    for (int c = 1; c <= 3; c++) begin
      chk("a4_err", m_err_o, 0);
      step();
    end
    s_ack_i = 3'b100;
    #1;
    chk("a4_ack", m_ack_o, 2'b01);
    chk("a4_err4", m_err_o, 0);
    chk("a4_rdat", m_dat_o, 32'h2222_2222);
    setm(0, 0, 0, 0, 0, 0);
    s_ack_i = '0;
    step();
    chk("a4_err5", m_err_o, 0);
    chk("a4_idle", m_gnt_o, 0);

    // ack in the pulse cycle wins over err
    setm(0, 1, 1, 0, 32'h2000_0000, 0);
    step();
    for (int c = 1; c <= 4; c++) step();
    chk("race_err_pre", m_err_o, 2'b01);
    s_ack_i = 3'b100;
    #1;
    chk("race_ack", m_ack_o, 2'b01);
    chk("race_err", m_err_o, 0);
    setm(0, 0, 0, 0, 0, 0);
    s_ack_i = '0;
    step();

    // reset while M0 owns the bus
    setm(0, 1, 1, 0, 32'h0000_0000, 0);
    step();
    chk("rm_gnt", m_gnt_o, 2'b01);
    chk("rm_stb", s_stb_o, 3'b001);
    #1 rst_i = 1'b0;
    #1;
    chk("rm_stb0", s_stb_o, 0);
    chk("rm_cyc0", s_cyc_o, 0);
    chk("rm_gnt0", m_gnt_o, 0);
    setm(0, 0, 0, 0, 0, 0);
    setm(1, 1, 1, 0, 32'h1000_0000, 0);
    #1 rst_i = 1'b1;
    #1;
    chk("rm_pre_gnt", m_gnt_o, 0);
    step();
    chk("rm_gnt1", m_gnt_o, 2'b10);
    chk("rm_stb1", s_stb_o, 3'b010);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
